// File: rtl/alu_share_arbiter.sv
// Shares one integer ALU between two requesters: accept, execute, respond.
// Optional ALU_ARB_RR_EN selects round-robin arbitration; default is fixed priority (client 0).
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [3:0]            req0_ctrl,
  input  logic [3:0]            req1_ctrl,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  grant_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] sel_op1_s;
  logic [DATA_WIDTH-1:0] sel_op2_s;
  logic [3:0]            sel_ctrl_s;
  logic [DATA_WIDTH-1:0] op1_r;
  logic [DATA_WIDTH-1:0] op2_r;
  logic [3:0]            ctrl_r;
  logic                  id_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  eq_r;
  logic                  resp_valid_r;

`ifdef ALU_ARB_RR_EN
  logic last_grant_r;

  // Round-robin grant: on a tie the client that did not win last time goes first
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // Remember the winner of each accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed-priority grant: client 0 wins whenever it is requesting
  always_comb begin
    if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end
`endif

  // Payload of the granted client
  always_comb begin
    if (grant_s) begin
      sel_op1_s  = req1_op1;
      sel_op2_s  = req1_op2;
      sel_ctrl_s = req1_ctrl;
    end else begin
      sel_op1_s  = req0_op1;
      sel_op2_s  = req0_op2;
      sel_ctrl_s = req0_ctrl;
    end
  end

  // Next-state and handshake decode; ready is only ever raised in IDLE
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept_s   = 1'b1;
          req0_ready = ~grant_s;
          req1_ready = grant_s;
          state_s    = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand and owner registers change only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_r  <= {DATA_WIDTH{1'b0}};
      op2_r  <= {DATA_WIDTH{1'b0}};
      ctrl_r <= 4'b0000;
      id_r   <= 1'b0;
    end else if (accept_s) begin
      op1_r  <= sel_op1_s;
      op2_r  <= sel_op2_s;
      ctrl_r <= sel_ctrl_s;
      id_r   <= grant_s;
    end else begin
      op1_r  <= op1_r;
      op2_r  <= op2_r;
      ctrl_r <= ctrl_r;
      id_r   <= id_r;
    end
  end

  // Result capture one cycle after acceptance, then held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {DATA_WIDTH{1'b0}};
      eq_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      data_r <= alu_out;
      eq_r   <= alu_eq;
    end else begin
      data_r <= data_r;
      eq_r   <= eq_r;
    end
  end

  // Response-valid flag registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= (state_s == RESP);
    end
  end

  assign alu_op1    = op1_r;
  assign alu_op2    = op2_r;
  assign alu_ctrl   = ctrl_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = id_r;
  assign resp_data  = data_r;
  assign resp_eq    = eq_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: environment ALU, transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [3:0]   req0_ctrl = 4'd0, req1_ctrl = 4'd0;
  logic [W-1:0] alu_op1, alu_op2, alu_out;
  logic [3:0]   alu_ctrl;
  logic         alu_eq;
  logic         resp_valid, resp_id, resp_eq;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_eq(alu_eq),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_eq(resp_eq)
  );

  // RV32 integer ALU, ctrl = {funct7[5], funct3}
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Branch condition by funct3
  function automatic logic br_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] c);
    case (c[2:0])
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_out = alu_fn(alu_op1, alu_op2, alu_ctrl);
    alu_eq  = br_fn(alu_op1, alu_op2, alu_ctrl);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // age: cycles since the in-flight op was accepted (0 = none); response is visible from age 2
  int           m_age = 0;
  logic [W-1:0] m_op1 = '0, m_op2 = '0, m_data = '0, p_data = '0;
  logic [3:0]   m_ctrl = 4'd0;
  logic         m_id = 1'b0, m_eq = 1'b0, p_eq = 1'b0, m_last = 1'b1;

  always @(negedge clk) begin : model_cmp
    logic g, anyv, e_r0, e_r1;
    anyv = req0_valid || req1_valid;
    g = req0_valid ? 1'b0 : 1'b1;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) g = ~m_last;
`endif
    e_r0 = (m_age == 0) && anyv && !g;
    e_r1 = (m_age == 0) && anyv && g;
    chk("m_req0_ready", req0_ready, e_r0);
    chk("m_req1_ready", req1_ready, e_r1);
    chk("m_resp_valid", resp_valid, m_age >= 2);
    chk("m_alu_op1", alu_op1, m_op1);
    chk("m_alu_op2", alu_op2, m_op2);
    chk("m_alu_ctrl", alu_ctrl, m_ctrl);
    chk("m_resp_id", resp_id, m_id);
    chk("m_resp_data", resp_data, m_data);
    chk("m_resp_eq", resp_eq, m_eq);
    // advance to the state after the coming rising edge
    if (rst) begin
      m_age = 0; m_op1 = '0; m_op2 = '0; m_ctrl = 4'd0;
      m_id = 1'b0; m_data = '0; m_eq = 1'b0; m_last = 1'b1;
    end else if (m_age == 0 && anyv) begin
      m_op1  = g ? req1_op1 : req0_op1;
      m_op2  = g ? req1_op2 : req0_op2;
      m_ctrl = g ? req1_ctrl : req0_ctrl;
      m_id   = g;
      m_last = g;
      p_data = alu_fn(m_op1, m_op2, m_ctrl);
      p_eq   = br_fn(m_op1, m_op2, m_ctrl);
      m_age  = 1;
    end else if (m_age == 1) begin
      m_data = p_data;
      m_eq   = p_eq;
      m_age  = 2;
    end else if (m_age >= 2 && resp_ready) begin
      m_age = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] ct);
    if (c) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_ctrl = ct;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_ctrl = ct;
    end
  endtask

  task automatic run_op(input bit c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] ct, output logic [W-1:0] d,
                        output logic e, output logic id);
    int n;
    drive(c, a, b, ct);
    #1;
    n = 0;
    while (!(c ? req1_ready : req0_ready) && n < 20) begin
      tick(); #1; n++;
    end
    chk("accept_bound", n < 20, 1'b1);
    tick();
    if (c) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick(); #1; n++;
    end
    chk("resp_bound", n < 20, 1'b1);
    d = resp_data; e = resp_eq; id = resp_id;
    tick();
  endtask

  logic [W-1:0] d;
  logic         e, id;
  int           g_log[$];
  int           r_log[$];
  int           exp_t[4];
  int           r1_cnt;
  bit           a0, a1;

  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 4'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", resp_id, 1'b0);
    tick();

    // single add with exact latency
    drive(1'b0, 32'd5, 32'd7, 4'b0000);
    #1;
    chk("add_ready0", req0_ready, 1'b1);
    chk("add_ready1", req1_ready, 1'b0);
    tick(); req0_valid = 1'b0; #1;
    chk("add_n1_valid", resp_valid, 1'b0);
    tick(); #1;
    chk("add_n2_valid", resp_valid, 1'b1);
    chk("add_data", resp_data, 32'd12);
    chk("add_id", resp_id, 1'b0);
    tick(); #1;
    chk("add_done", resp_valid, 1'b0);
    tick();

    // subtract under backpressure
    resp_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd5, 4'b1000);
    #1;
    chk("sub_ready1", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sub_hold_valid", resp_valid, 1'b1);
      chk("sub_hold_data", resp_data, 32'hFFFF_FFFE);
      chk("sub_hold_id", resp_id, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("sub_last_valid", resp_valid, 1'b1);
    tick(); #1;
    chk("sub_idle", resp_valid, 1'b0);
    tick();

    // branch flag, signed vs unsigned
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0100, d, e, id);
    chk("blt_eq", e, 1'b1);
    chk("blt_id", id, 1'b1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0110, d, e, id);
    chk("bltu_eq", e, 1'b0);

    // tie: both valids held for four operations from reset
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b0, 32'd10, 32'd20, 4'b0000);
    drive(1'b1, 32'd30, 32'd40, 4'b1000);
    r1_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) g_log.push_back(0);
      if (req1_ready) begin g_log.push_back(1); r1_cnt++; end
      if (resp_valid && resp_ready) r_log.push_back(int'(resp_id));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_t = '{0, 1, 0, 1};
`else
    exp_t = '{0, 0, 0, 0};
    chk("fp_req1_never", r1_cnt, 32'd0);
`endif
    chk("tie_grants", g_log.size(), 32'd4);
    chk("tie_resps", r_log.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("tie_grant", (k < g_log.size()) ? g_log[k] : 9, exp_t[k]);
      chk("tie_resp_id", (k < r_log.size()) ? r_log[k] : 9, exp_t[k]);
    end
    tick();

    // reset during EXEC discards the op
    drive(1'b0, 32'd1, 32'd1, 4'b0000);
    #1;
    chk("rst_mid_accept", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst_mid_valid", resp_valid, 1'b0);
    chk("rst_mid_op1", alu_op1, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("rst_mid_noresp", resp_valid, 1'b0);
    end
    tick();
    run_op(1'b1, 32'h0000_00F0, 32'h0000_00FF, 4'b0100, d, e, id);
    chk("xor_data", d, 32'h0000_000F);
    chk("xor_id", id, 1'b1);

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_r0", req0_ready, 1'b0);
      chk("idle_r1", req1_ready, 1'b0);
      chk("idle_valid", resp_valid, 1'b0);
      chk("idle_op1", alu_op1, 32'h0000_00F0);
      chk("idle_op2", alu_op2, 32'h0000_00FF);
      chk("idle_ctrl", alu_ctrl, 4'b0100);
      tick();
    end

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(1, 0) == 1) begin
        req0_op1 = $urandom;
        req0_op2 = ($urandom_range(3, 0) == 0) ? req0_op1 : $urandom;
        req0_ctrl = 4'($urandom_range(15, 0));
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(1, 0) == 1) begin
        req1_op1 = $urandom;
        req1_op2 = ($urandom_range(3, 0) == 0) ? req1_op1 : $urandom;
        req1_ctrl = 4'($urandom_range(15, 0));
        req1_valid = 1'b1;
      end
      resp_ready = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(63, 0) == 0);
      #1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end

    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that shares the single integer ALU between two requesters, for example the execute stage (client 0) and the branch/address-generation unit (client 1). It accepts one operation at a time through a valid/ready handshake and latches its operands into registers that drive the ALU. It captures the ALU's result and branch flag one cycle later and returns them on a shared response port tagged with the requester ID. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  client n has an operation pending
- req0_ready / req1_ready  output  1  client n's operation is accepted this cycle
- req0_op1, req0_op2, req1_op1, req1_op2  input  DATA_WIDTH  operands
- req0_ctrl / req1_ctrl  input  4  ALU control {funct7[5], funct3[2:0]}
- alu_op1, alu_op2  output  DATA_WIDTH  to ALU operand inputs
- alu_ctrl  output  4  to ALU control input
- alu_out  input  DATA_WIDTH  ALU combinational result
- alu_eq  input  1  ALU branch-condition flag
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts the result
- resp_id  output  1  requester that owns the result (0/1)
- resp_data  output  DATA_WIDTH  captured alu_out
- resp_eq  output  1  captured alu_eq

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If no reqN_valid is high, stay in IDLE.
  - Otherwise compute grant (see Configuration).
  - Assert the granted client's reqN_ready combinationally in the same cycle; the other client's ready stays 0.
  - At the clock edge, latch that client's op1/op2/ctrl into the operand registers, latch its ID into the ID register, and go to EXEC.
- EXEC:
  - Operand registers drive alu_op1/alu_op2/alu_ctrl.
  - At the edge, capture alu_out into resp_data and alu_eq into resp_eq, then go to RESP.
- RESP:
  - resp_valid=1.
  - If resp_ready is high, go to IDLE at the edge. Otherwise hold with resp_data/resp_eq/resp_id stable.
- Handshake rules:
  - reqN_ready is 0 in EXEC and RESP.
  - A requester must hold its valid and payload until it sees ready.
  - resp_valid never drops without resp_ready.
- alu_op1/alu_op2/alu_ctrl always reflect the operand registers, including in IDLE and RESP. They change only on acceptance.
- Pure width pass-through, no arithmetic in this block. resp_eq is meaningful only to the client that issued a branch ctrl.

## Timing
- Reset values:
  - state=IDLE.
  - alu_op1=0, alu_op2=0, alu_ctrl=0.
  - resp_valid=0, resp_id=0, resp_data=0, resp_eq=0.
  - req0_ready=0, req1_ready=0 (ready is gated by valid).
  - last_grant=1.
- Latency: accept at cycle N → resp_valid at N+2.
- Minimum issue interval: 3 cycles, when resp_ready is held high.
- A new request is not accepted in the same cycle the response is consumed. IDLE is always visited.
- Simultaneous valids are resolved only in IDLE. A request arriving during EXEC/RESP waits.
- rst asserted in any state, including mid-EXEC or RESP with resp_ready low:
  - The in-flight op is discarded.
  - All registers return to their reset values on that edge.
  - No response is produced for the discarded op.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the client that is not last_grant.
  - last_grant updates on each acceptance.
  - Reset value last_grant=1, so client 0 wins the first tie.
  - A single requester is always granted.
- ALU_ARB_RR_EN undefined: fixed priority.
  - Client 0 always wins a tie.
  - last_grant is not implemented.

## Test plan
- Single add: req0, op1=5, op2=7, ctrl=4'b0000 at cycle N → req0_ready=1 at N, resp_valid at N+2 with resp_data=12, resp_id=0.
- Subtract with backpressure: req1, op1=3, op2=5, ctrl=4'b1000; resp_ready low for 4 cycles → resp_valid held with resp_data=0xFFFFFFFE and resp_id=1 stable throughout; IDLE on the cycle after resp_ready rises.
- Branch flag: req1, op1=0xFFFFFFFF, op2=1, ctrl=4'b0100 (BLT) → resp_eq=1. Same operands with ctrl=4'b0110 (BLTU) → resp_eq=0.
- Tie, both valids held high for 4 ops:
  - with ALU_ARB_RR_EN → resp_id sequence 0,1,0,1;
  - without it → 0,0,0,0, and req1_ready never asserts.
- Reset mid-op: accept req0 (add 1+1), assert rst during EXEC → resp_valid=0 next cycle, alu_op1=0, no response for 2. A following req1 (xor 0xF0^0xFF, ctrl=4'b0100) → resp_data=0x0F, resp_id=1.
- No-valid idle: both valids low for 10 cycles → both readys=0, resp_valid=0, alu_* unchanged.
